// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with a bounded lock so one port can hold the memory for a burst.
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  output logic          mem_read_en,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            lock_q, lock_d;
  logic [7:0]      hold_q, hold_d;
  logic            m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0]   m0_rdata_q, m1_rdata_q;
  logic            owner_valid, owner, keep_owner, pick1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    m0_gnt         = 1'b0;
    m1_gnt         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    lock_d         = lock_q;
    hold_d         = hold_q;
    owner_valid    = (state_q != IDLE);
    owner          = (state_q == OWN1);
    keep_owner     = owner_valid && lock_q && (hold_q < HOLD_LIM);
    pick1          = keep_owner ? owner : ~last_grant_q;

    // Grant and memory drive are gated by rst_n so they fall the instant reset asserts.
    if (rst_n) begin
      if (m0_req && m1_req) begin
        m1_gnt = pick1;
        m0_gnt = ~pick1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end

    if (m1_gnt) begin
      mem_addr       = m1_addr;
      mem_write_en   = m1_we;
      mem_read_en    = ~m1_we;
      mem_write_data = m1_we ? m1_wdata : '0;
    end else if (m0_gnt) begin
      mem_addr       = m0_addr;
      mem_write_en   = m0_we;
      mem_read_en    = ~m0_we;
      mem_write_data = m0_we ? m0_wdata : '0;
    end

    if (m0_gnt || m1_gnt) begin
      state_d      = m1_gnt ? OWN1 : OWN0;
      last_grant_d = m1_gnt;
      lock_d       = m1_gnt ? m1_lock : m0_lock;
      if (owner_valid && (owner == m1_gnt))
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
      else
        hold_d = 8'd0;
    end else begin
      state_d = IDLE;
      hold_d  = 8'd0;
      lock_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      hold_q       <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt && !m0_we;
      m1_rvalid_q <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= mem_read_data;
      if (m1_gnt && !m1_we) m1_rdata_q <= mem_read_data;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model
// of the two-port round-robin arbiter with bounded lock.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit          req [2];
  bit          we  [2];
  bit          lock[2];
  logic [15:0] addr[2];
  logic [15:0] wdata[2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write_en, mem_read_en;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  function automatic logic [15:0] init_word(int i);
    if (i == 5) return 16'h1234;
    return 16'((i * 257) ^ 23130);
  endfunction

  // Memory device: combinational read, write committed at the rising edge.
  logic [15:0] mem[256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_write_en) begin
      mem[mem_addr[7:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_addr[7:0]];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: who owned the memory, for how many grants in a row,
  // whether it asked to keep it, and a shadow copy of the memory contents.
  int          last_grant, prev_owner, streak, last_win;
  bit          prev_lock;
  bit          exp_rv[2];
  logic [15:0] exp_rd[2];
  logic [15:0] ref_mem[256];

  task automatic model_reset();
    last_grant = 1;
    prev_owner = -1;
    streak     = 0;
    prev_lock  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0;
      exp_rd[p] = 16'h0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  function automatic int decide();
    if (req[0] && !req[1]) return 0;
    if (req[1] && !req[0]) return 1;
    if (!req[0] && !req[1]) return -1;
    if (prev_owner >= 0 && prev_lock && streak < MAX_HOLD) return prev_owner;
    return 1 - last_grant;
  endfunction

  // Entered at posedge+1 with inputs set; checks at posedge+3, then advances one cycle.
  task automatic step();
    int w;
    logic [15:0] ea, ewd;
    bit ewe, ere;
    #2;
    w = decide();
    ea = 16'h0; ewd = 16'h0; ewe = 1'b0; ere = 1'b0;
    if (w >= 0) begin
      ea  = addr[w];
      ewe = we[w];
      ere = !we[w];
      ewd = we[w] ? wdata[w] : 16'h0;
    end
    check("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_write_en", 32'(mem_write_en), 32'(ewe));
    check("mem_read_en", 32'(mem_read_en), 32'(ere));
    check("mem_write_data", 32'(mem_write_data), 32'(ewd));
    check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    check("m0_rdata", 32'(m0_rdata), 32'(exp_rd[0]));
    check("m1_rdata", 32'(m1_rdata), 32'(exp_rd[1]));

    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (w >= 0) begin
      streak     = (w == prev_owner) ? streak + 1 : 1;
      prev_owner = w;
      prev_lock  = lock[w];
      last_grant = w;
      if (we[w]) begin
        ref_mem[addr[w][7:0]] = wdata[w];
      end else begin
        exp_rv[w] = 1'b1;
        exp_rd[w] = ref_mem[addr[w][7:0]];
      end
    end else begin
      prev_owner = -1;
      streak     = 0;
    end
    last_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, bit r, bit w, bit l, logic [15:0] a, logic [15:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
  endtask

  int lock_seq[6] = '{1, 1, 1, 0, 1, 1};
  bit pending[2];
  int prev_win;

  initial begin
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    model_reset();

    // Reset state with requests already pending.
    #3;
    set_port(0, 1, 0, 0, 16'd5, 16'h0);
    set_port(1, 1, 1, 0, 16'd9, 16'h77);
    #1;
    check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    check("rst_mem_re", 32'(mem_read_en), 32'd0);
    check("rst_mem_we", 32'(mem_write_en), 32'd0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read of preloaded word.
    set_port(0, 1, 0, 0, 16'd5, 16'h0);
    step();
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    check("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("t1_m0_rdata", 32'(m0_rdata), 32'h1234);
    check("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    step();

    // Both reading continuously without lock: grants must alternate.
    set_port(0, 1, 0, 0, 16'd1, 16'h0);
    set_port(1, 1, 0, 0, 16'd2, 16'h0);
    step();
    prev_win = last_win;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_alternate", 32'(last_win), 32'(1 - prev_win));
      prev_win = last_win;
    end
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    step();

    // Locked burst on port 1 bounded at MAX_HOLD consecutive grants.
    set_port(1, 1, 0, 1, 16'd3, 16'h0);
    step();
    check("lock_first", 32'(last_win), 32'd1);
    set_port(0, 1, 0, 0, 16'd4, 16'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("lock_seq", 32'(last_win), 32'(lock_seq[i]));
    end
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    step();

    // Write then read-after-write from the other port.
    set_port(0, 1, 1, 0, 16'd7, 16'hBEEF);
    step();
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 1, 0, 0, 16'd7, 16'h0);
    step();
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    check("raw_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("raw_m1_rdata", 32'(m1_rdata), 32'hBEEF);
    step();

    // Asynchronous reset while a read response is pending.
    set_port(0, 1, 0, 0, 16'd3, 16'h0);
    step();
    check("pre_rst_rvalid", 32'(m0_rvalid), 32'd1);
    set_port(1, 1, 0, 0, 16'd6, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("async_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    check("async_mem_addr", 32'(mem_addr), 32'd0);
    check("async_mem_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    model_reset();
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_port(0, 1, 0, 0, 16'd8, 16'h0);
    set_port(1, 1, 0, 0, 16'd9, 16'h0);
    step();
    check("post_rst_first", 32'(last_win), 32'd0);
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);

    // Idle period.
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic; requests stay stable until granted.
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pending[p] && ($urandom_range(0, 3) != 0)) begin
          pending[p] = 1'b1;
          set_port(p, 1, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom_range(0, 15)),
                   16'($urandom));
        end
        req[p]  = pending[p];
        lock[p] = ($urandom_range(0, 3) != 0);
      end
      step();
      if (last_win >= 0) pending[last_win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
